// File: rtl/sh4_fpu_norm_sched.sv
// rtl/sh4_fpu_norm_sched.sv - round-robin shared normaliser (leading-zero count + left shift), 2-stage pipeline
// FADD/FMUL/FLOAT requesters share one LZC and shifter; results carry the requester ID back out.

module sh4_fpu_norm_lzc #(
  parameter  int WIDTH  = 32,
  localparam int SWIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  data_i,
  output logic [SWIDTH-1:0] count_o,
  output logic              zero_o
);

  // Scanning upward lets the most significant set bit win; a zero operand keeps count 0.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = SWIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign zero_o = ~|data_i;

endmodule

module sh4_fpu_norm_sched #(
  parameter  int WIDTH  = 32,
  parameter  int NREQ   = 3,
  localparam int SWIDTH = $clog2(WIDTH),
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [SWIDTH-1:0]     rsp_count,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero
);

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              valid_a_q, valid_a_d;
  logic [WIDTH-1:0]  data_a_q, data_a_d;
  logic [IDW-1:0]    id_a_q, id_a_d;
  logic              valid_b_q, valid_b_d;
  logic [WIDTH-1:0]  data_b_q, data_b_d;
  logic [SWIDTH-1:0] count_b_q, count_b_d;
  logic [IDW-1:0]    id_b_q, id_b_d;
  logic              zero_b_q, zero_b_d;

  logic              en_a, en_b, issue_ok, xfer;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gnt_id, rot_idx;
  logic              gnt_found;
  logic [WIDTH-1:0]  gnt_data;
  logic [SWIDTH-1:0] lz_count;
  logic              lz_zero;

  assign en_b     = ~valid_b_q | rsp_ready;
  assign en_a     = ~valid_a_q | en_b;
  assign issue_ok = en_a & ~flush & rst_n;

  // First valid requester at or above ptr, wrapping at NREQ.
  always_comb begin
    grant     = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    rot_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[rot_idx]) begin
        gnt_found      = 1'b1;
        gnt_id         = rot_idx;
        grant[rot_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        gnt_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = grant & {NREQ{issue_ok}};
  assign xfer      = gnt_found & issue_ok;

  sh4_fpu_norm_lzc #(.WIDTH(WIDTH)) u_lzc (
    .data_i  (data_a_q),
    .count_o (lz_count),
    .zero_o  (lz_zero)
  );

  always_comb begin
    ptr_d     = ptr_q;
    valid_a_d = valid_a_q;
    data_a_d  = data_a_q;
    id_a_d    = id_a_q;
    valid_b_d = valid_b_q;
    data_b_d  = data_b_q;
    count_b_d = count_b_q;
    id_b_d    = id_b_q;
    zero_b_d  = zero_b_q;
    if (flush) begin
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
    end else begin
      // B only reloads when A actually moves, so stalled outputs never glitch.
      if (en_b) begin
        valid_b_d = valid_a_q;
        if (valid_a_q) begin
          data_b_d  = data_a_q << lz_count;
          count_b_d = lz_count;
          id_b_d    = id_a_q;
          zero_b_d  = lz_zero;
        end
      end
      if (en_a) begin
        valid_a_d = xfer;
        if (xfer) begin
          data_a_d = gnt_data;
          id_a_d   = gnt_id;
          ptr_d    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      valid_a_q <= 1'b0;
      data_a_q  <= '0;
      id_a_q    <= '0;
      valid_b_q <= 1'b0;
      data_b_q  <= '0;
      count_b_q <= '0;
      id_b_q    <= '0;
      zero_b_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      valid_a_q <= valid_a_d;
      data_a_q  <= data_a_d;
      id_a_q    <= id_a_d;
      valid_b_q <= valid_b_d;
      data_b_q  <= data_b_d;
      count_b_q <= count_b_d;
      id_b_q    <= id_b_d;
      zero_b_q  <= zero_b_d;
    end
  end

  assign rsp_valid = valid_b_q;
  assign rsp_id    = id_b_q;
  assign rsp_count = count_b_q;
  assign rsp_data  = data_b_q;
  assign rsp_zero  = zero_b_q;

endmodule

// File: tb/tb_sh4_fpu_norm_sched.sv
// tb/tb_sh4_fpu_norm_sched.sv - directed and random checks of the shared normaliser against a FIFO reference model
module tb_sh4_fpu_norm_sched;

  localparam int WIDTH  = 32;
  localparam int NREQ   = 3;
  localparam int SWIDTH = $clog2(WIDTH);
  localparam int IDW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n, flush, rsp_ready;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  rsp_valid, rsp_zero;
  logic [IDW-1:0]        rsp_id;
  logic [SWIDTH-1:0]     rsp_count;
  logic [WIDTH-1:0]      rsp_data;

  always #5 clk = ~clk;

  sh4_fpu_norm_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] op;
    bit               aged;
  } ent_t;

  ent_t mq[$];
  int   mptr       = 0;
  bit   keep_valid = 1'b0;
  int   dut_xfers  = 0;
  int   n_assert   = 0;
  int   n_fail     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Normalise by repeated doubling until the top bit is set.
  task automatic ref_norm(input logic [WIDTH-1:0] x, output int cnt,
                          output logic [WIDTH-1:0] d, output bit z);
    cnt = 0;
    d   = x;
    z   = (x == '0);
    if (!z) begin
      while (!d[WIDTH-1]) begin
        d = d << 1;
        cnt++;
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    logic [WIDTH-1:0] r   = $urandom;
    logic [WIDTH-1:0] one = 1;
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return one << $urandom_range(0, WIDTH - 1);
      2:       return r >> $urandom_range(0, WIDTH - 1);
      default: return r;
    endcase
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int               g, xid, cnt;
    bit               ok, pop, exp_rv, nz, cap_rst, cap_flush;
    logic [WIDTH-1:0] nd, cap_op;
    logic [NREQ-1:0]  exp_ready;
    ent_t             e;
    cap_op = '0;
    @(negedge clk);
    exp_rv = (mq.size() > 0) && mq[0].aged;
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      ref_norm(mq[0].op, cnt, nd, nz);
      chk("rsp_id", rsp_id, mq[0].id);
      chk("rsp_count", rsp_count, cnt);
      chk("rsp_data", rsp_data, nd);
      chk("rsp_zero", rsp_zero, nz);
    end
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (mptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    ok = rst_n && !flush && (mq.size() < 2 || rsp_ready);
    exp_ready = '0;
    if (ok && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    dut_xfers += $countones(req_valid & req_ready);
    xid = (ok && g >= 0) ? g : -1;
    if (xid >= 0) cap_op = req_data[xid*WIDTH +: WIDTH];
    pop       = exp_rv && rsp_ready;
    cap_rst   = rst_n;
    cap_flush = flush;
    @(posedge clk);
    if (!cap_rst) begin
      mq.delete();
      mptr = 0;
    end else if (cap_flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      foreach (mq[i]) mq[i].aged = 1'b1;
      if (xid >= 0) begin
        e.id   = xid;
        e.op   = cap_op;
        e.aged = 1'b0;
        mq.push_back(e);
        mptr = (xid + 1) % NREQ;
      end
    end
    #1;
    if (xid >= 0) begin
      if (keep_valid) req_data[xid*WIDTH +: WIDTH] = rand_operand();
      else req_valid[xid] = 1'b0;
    end
  endtask

  logic [WIDTH-1:0]  bop   [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
  logic [SWIDTH-1:0] bcnt  [3] = '{5'd0, 5'd31, 5'd0};
  logic [WIDTH-1:0]  bdata [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
  logic              bzero [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    req_data  = {32'h0000_00A0, 32'h0000_0000, 32'h0000_FFFF};

    repeat (3) cycle();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_count", rsp_count, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_zero", rsp_zero, 0);

    rst_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 3'b001);
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();

    req_data[1*WIDTH +: WIDTH] = 32'h0000_1234;
    req_valid = 3'b010;
    cycle();
    cycle();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 1);
    chk("single_count", rsp_count, 19);
    chk("single_data", rsp_data, 32'h91A0_0000);
    chk("single_zero", rsp_zero, 0);

    for (int t = 0; t < 3; t++) begin
      req_data[2*WIDTH +: WIDTH] = bop[t];
      req_valid = 3'b100;
      cycle();
      cycle();
      chk("bound_valid", rsp_valid, 1);
      chk("bound_count", rsp_count, bcnt[t]);
      chk("bound_data", rsp_data, bdata[t]);
      chk("bound_zero", rsp_zero, bzero[t]);
    end

    req_valid  = '1;
    keep_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (c > 0) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (c - 1) % NREQ);
      end
    end
    req_valid  = '0;
    keep_valid = 1'b0;
    cycle();
    cycle();

    rsp_ready  = 1'b0;
    req_valid  = 3'b101;
    keep_valid = 1'b1;
    dut_xfers  = 0;
    cycle();
    cycle();
    chk("bp_first_id", rsp_id, 2);
    cycle();
    cycle();
    chk("bp_accepts", dut_xfers, 2);
    chk("bp_full_ready", req_ready, 0);
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_held_id", rsp_id, 2);
    req_valid  = '0;
    keep_valid = 1'b0;
    rsp_ready  = 1'b1;
    cycle();
    chk("bp_drain_valid", rsp_valid, 1);
    chk("bp_drain_id", rsp_id, 0);
    cycle();
    chk("bp_empty", rsp_valid, 0);

    rsp_ready  = 1'b0;
    req_valid  = '1;
    keep_valid = 1'b1;
    cycle();
    cycle();
    chk("fl_full_ready", req_ready, 0);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_rsp_valid", rsp_valid, 0);
    #1;
    chk("fl_next_grant", req_ready, 3'b001);
    cycle();
    cycle();
    chk("fl_resume_valid", rsp_valid, 1);
    chk("fl_resume_id", rsp_id, 0);
    req_valid  = '0;
    keep_valid = 1'b0;
    cycle();
    cycle();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = rand_operand();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 255) != 0);
      cycle();
    end
    rst_n     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cycle();
    chk("final_idle", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
